// File: rtl/pix_pkg.sv
// pix_pkg: shared widths and writer state encoding for the pixel frame writer
package pix_pkg;
    localparam int PIX_W = 4;
    localparam int PIX_PER_WORD = 4;
    localparam int WORD_W = 16;
    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} wr_state_t;
endpackage

// File: rtl/wr_fifo.sv
// wr_fifo: first-word-fall-through FIFO; a push while full is taken only if a pop frees the slot
module wr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic wr, rd;
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign wr    = push && (!full || pop);
    assign rd    = pop && !empty;
    assign dout  = mem[rp];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (rd) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end
endmodule

// File: rtl/pixel_frame_writer.sv
// pixel_frame_writer: packs a 4-bit pixel stream into 16-bit words and writes one frame to SRAM
module pixel_frame_writer
    import pix_pkg::*;
#(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_W     = 18,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [3:0]        pixel_in,
    input  logic              in_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int PCW  = $clog2(NPIX + 1);
    localparam int FW   = ADDR_W + WORD_W;
    wr_state_t state, nxt;
    logic [PCW-1:0] pix_cnt;
    logic [1:0] nib;
    logic [(PIX_PER_WORD-1)*PIX_W-1:0] pack;
    logic [ADDR_W-1:0] word_idx;
    logic accept, last, push, pop, full, empty, arm;
    logic [FW-1:0] head;
    assign arm    = state == IDLE && frame_start;
    assign accept = state == CAPTURE && in_valid;
    assign last   = accept && pix_cnt == PCW'(NPIX - 1);
    assign push   = accept && nib == 2'd3;
    assign pop    = mem_we && mem_ack;
    assign mem_we    = !empty;
    assign mem_addr  = empty ? '0 : head[FW-1:WORD_W];
    assign mem_wdata = empty ? '0 : head[WORD_W-1:0];
    wr_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .din({ADDR_W'(BASE_ADDR) + word_idx, pixel_in, pack}),
        .dout(head),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        busy = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: if (frame_start) nxt = CAPTURE;
            CAPTURE: begin
                busy = 1'b1;
                if (last) nxt = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (empty) nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
    // word_idx advances even on a dropped word so later addresses stay correct
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt  <= '0;
            nib      <= '0;
            pack     <= '0;
            word_idx <= '0;
            overflow <= 1'b0;
        end else if (arm) begin
            pix_cnt  <= '0;
            nib      <= '0;
            word_idx <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            pix_cnt <= pix_cnt + PCW'(1);
            nib     <= nib + 2'd1;
            pack    <= {pixel_in, pack[(PIX_PER_WORD-1)*PIX_W-1:PIX_W]};
            if (push) word_idx <= word_idx + ADDR_W'(1);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pixel_frame_writer.sv
// tb_pixel_frame_writer: scoreboard bench on an 8x2 frame at 0x100 with a 2-entry FIFO
module tb_pixel_frame_writer;
    logic clk = 1'b0, rst = 1'b1, frame_start = 1'b0, in_valid = 1'b0, mem_ack = 1'b0;
    logic [3:0] pixel_in = 4'h0;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic mem_we, busy, frame_done, overflow;
    int vectors = 0, errs = 0, done_cnt = 0;
    logic [33:0] q[$];
    logic [15:0] wexp [4];
    always #5 clk = ~clk;
    pixel_frame_writer #(
        .IMG_W(8), .IMG_H(2), .BASE_ADDR('h100), .ADDR_W(18), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_in(pixel_in),
        .in_valid(in_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_ack(mem_ack), .busy(busy),
        .frame_done(frame_done), .overflow(overflow)
    );
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask
    // monitor: retires one scoreboard entry per completed write
    initial forever begin
        @(negedge clk);
        #4;
        if (frame_done) done_cnt++;
        if (mem_we && mem_ack) begin
            if (q.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL unexpected_write: got %h@%h want none", mem_wdata, mem_addr);
            end else chk("write", 64'({mem_addr, mem_wdata}), 64'(q.pop_front()));
        end
    end
    task automatic cyc(input logic fs, input logic v, input logic [3:0] p);
        @(negedge clk);
        frame_start = fs;
        in_valid = v;
        pixel_in = p;
    endtask
    task automatic expect_words(input int n);
        for (int i = 0; i < n; i++) q.push_back({18'(32'h100 + i), wexp[i]});
    endtask
    task automatic send_frame();
        cyc(1, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 1, 4'(i));
        cyc(0, 0, 0);
    endtask
    task automatic finish_frame(input int d0, input logic ovf);
        int t = 0;
        while (done_cnt == d0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk("done_pulses", 64'(done_cnt - d0), 64'(1));
        chk("busy_after", 64'(busy), 64'(0));
        chk("overflow", 64'(overflow), 64'(ovf));
        chk("queue_drained", 64'(q.size()), 64'(0));
    endtask
    task automatic reset_mid(input logic a);
        mem_ack = a;
        if (a) expect_words(1);
        cyc(1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 4'(i));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("we_before_rst", 64'(mem_we), 64'(!a));
        chk("busy_before_rst", 64'(busy), 64'(1));
        #1 rst = 1'b1;
        #1;
        chk("rst_we", 64'(mem_we), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_queue", 64'(q.size()), 64'(0));
        q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int d0, p, c;
        wexp[0] = 16'h3210; wexp[1] = 16'h7654; wexp[2] = 16'hBA98; wexp[3] = 16'hFEDC;
        repeat (3) @(negedge clk);
        chk("reset_we", 64'(mem_we), 64'(0));
        chk("reset_addr", 64'(mem_addr), 64'(0));
        chk("reset_wdata", 64'(mem_wdata), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(frame_done), 64'(0));
        chk("reset_overflow", 64'(overflow), 64'(0));
        rst = 1'b0;
        // basic frame
        mem_ack = 1'b1;
        d0 = done_cnt;
        expect_words(4);
        send_frame();
        finish_frame(d0, 0);
        // ack stall for 5 cycles on the first write
        mem_ack = 1'b0;
        d0 = done_cnt;
        expect_words(4);
        fork
            send_frame();
            begin
                int t = 0;
                do begin
                    @(negedge clk);
                    #4;
                    t++;
                end while (!mem_we && t < 100);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        #4;
                    end
                    chk("stall_we", 64'(mem_we), 64'(1));
                    chk("stall_addr", 64'(mem_addr), 64'(18'h100));
                    chk("stall_wdata", 64'(mem_wdata), 64'(16'h3210));
                end
                @(negedge clk);
                mem_ack = 1'b1;
            end
        join
        finish_frame(d0, 0);
        // overflow with the FIFO held full
        mem_ack = 1'b0;
        d0 = done_cnt;
        expect_words(2);
        send_frame();
        repeat (3) cyc(0, 0, 0);
        chk("ovf_mid", 64'(overflow), 64'(1));
        chk("ovf_busy", 64'(busy), 64'(1));
        @(negedge clk);
        mem_ack = 1'b1;
        finish_frame(d0, 1);
        // gapped input, stray frame_start in CAPTURE, surplus pixels afterwards
        mem_ack = 1'b1;
        d0 = done_cnt;
        expect_words(4);
        cyc(1, 0, 0);
        p = 0;
        c = 0;
        while (p < 16) begin
            cyc(c == 9, (c % 4 == 0) || (c % 4 == 3), 4'(p));
            if ((c % 4 == 0) || (c % 4 == 3)) p++;
            c++;
        end
        repeat (3) cyc(0, 1, 4'hA);
        cyc(0, 0, 0);
        finish_frame(d0, 0);
        // reset mid-frame, then a clean frame
        reset_mid(1);
        reset_mid(0);
        mem_ack = 1'b1;
        d0 = done_cnt;
        expect_words(4);
        send_frame();
        finish_frame(d0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
